// File: rtl/hazard_pkg.sv
// Shared opcode constants and FSM state type for the hazard stall unit.
package hazard_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_LW    = 6'b100011;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    STALL  = 2'd1,
    FREEZE = 2'd2
  } hz_state_t;

endpackage

// File: rtl/hazard_dep_cmp.sv
// Register dependency comparator: does a producer destination feed the IF/ID
// instruction's sources? Register 0 is hard-wired and never creates a dependency.
module hazard_dep_cmp #(
  parameter int REG_W = 5
) (
  input  logic [REG_W-1:0] rd,
  input  logic [REG_W-1:0] rs,
  input  logic [REG_W-1:0] rt,
  input  logic             uses_rt,
  output logic             dep
);

  // Match on rs always, on rt only when the instruction actually reads it.
  always_comb begin
    dep = (rd != '0) && ((rd == rs) || (uses_rt && (rd == rt)));
  end

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/flush controller for the 5-stage MIPS pipeline: load-use and branch
// operand stalls, data-memory freeze, IF/ID flush and a stall-cycle counter.
module hazard_stall_unit
  import hazard_pkg::*;
#(
  parameter int REG_W  = 5,
  parameter int OP_W   = 6,
  parameter int CNT_W  = 2,
  parameter int PERF_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [OP_W-1:0]   id_op,
  input  logic [REG_W-1:0]  id_rs,
  input  logic [REG_W-1:0]  id_rt,
  input  logic              id_ex_mem_read,
  input  logic              id_ex_reg_write,
  input  logic [REG_W-1:0]  id_ex_rd,
  input  logic              ex_mem_mem_read,
  input  logic [REG_W-1:0]  ex_mem_rd,
  input  logic              branch_taken,
  input  logic              jump,
  input  logic              mem_busy,
  output logic              pc_en,
  output logic              if_id_en,
  output logic              pipe_en,
  output logic              id_ex_bubble,
  output logic              if_id_flush,
  output logic [PERF_W-1:0] stall_cycles
);

  hz_state_t         state_q, state_d, eff_state;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [PERF_W-1:0] stall_cycles_q, stall_cycles_d;

  logic              uses_rt, is_br;
  logic              dep_ex, dep_mem;
  logic              lu_haz, br1, br2;
  logic [CNT_W-1:0]  need;
  logic              stall, freeze;

  hazard_dep_cmp #(.REG_W(REG_W)) u_dep_ex (
    .rd      (id_ex_rd),
    .rs      (id_rs),
    .rt      (id_rt),
    .uses_rt (uses_rt),
    .dep     (dep_ex)
  );

  hazard_dep_cmp #(.REG_W(REG_W)) u_dep_mem (
    .rd      (ex_mem_rd),
    .rs      (id_rs),
    .rt      (id_rt),
    .uses_rt (uses_rt),
    .dep     (dep_mem)
  );

  // Hazard classification: how many stall cycles the IF/ID instruction needs.
  always_comb begin
    uses_rt = (id_op == OP_W'(OP_RTYPE)) || (id_op == OP_W'(OP_BEQ)) ||
              (id_op == OP_W'(OP_BNE))   || (id_op == OP_W'(OP_SW));
    is_br   = (id_op == OP_W'(OP_BEQ)) || (id_op == OP_W'(OP_BNE));
    lu_haz  = id_ex_mem_read && dep_ex;
    br1     = is_br && ((id_ex_reg_write && !id_ex_mem_read && dep_ex) ||
                        (ex_mem_mem_read && dep_mem));
    br2     = is_br && id_ex_mem_read && dep_ex;
    if (br2)                 need = CNT_W'(2);
    else if (lu_haz || br1)  need = CNT_W'(1);
    else                     need = '0;
  end

  // State, sequence counter and saturating perf counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= RUN;
      cnt_q          <= '0;
      stall_cycles_q <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      stall_cycles_q <= stall_cycles_d;
    end
  end

  // Next-state logic; leaving FREEZE behaves as the state being resumed.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    stall     = 1'b0;
    freeze    = 1'b0;
    eff_state = state_q;
    if (state_q == FREEZE) eff_state = (cnt_q != '0) ? STALL : RUN;
    if (mem_busy) begin
      freeze  = 1'b1;
      state_d = FREEZE;
    end else begin
      case (eff_state)
        STALL: begin
          stall   = 1'b1;
          cnt_d   = (cnt_q != '0) ? cnt_q - CNT_W'(1) : '0;
          state_d = (cnt_q <= CNT_W'(1)) ? RUN : STALL;
        end
        default: begin
          state_d = RUN;
          if (need != '0) begin
            stall   = 1'b1;
            cnt_d   = need - CNT_W'(1);
            state_d = (need > CNT_W'(1)) ? STALL : RUN;
          end
        end
      endcase
    end
    if ((stall || freeze) && (stall_cycles_q != '1))
      stall_cycles_d = stall_cycles_q + PERF_W'(1);
    else
      stall_cycles_d = stall_cycles_q;
  end

  // Output decode; reset forces a frozen, bubbled, flushed pipeline.
  always_comb begin
    pc_en        = 1'b1;
    if_id_en     = 1'b1;
    pipe_en      = 1'b1;
    id_ex_bubble = 1'b0;
    if_id_flush  = 1'b0;
    if (!rst_n) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      pipe_en      = 1'b0;
      id_ex_bubble = 1'b1;
      if_id_flush  = 1'b1;
    end else if (freeze) begin
      pc_en    = 1'b0;
      if_id_en = 1'b0;
      pipe_en  = 1'b0;
    end else if (stall) begin
      pc_en        = 1'b0;
      if_id_en     = 1'b0;
      id_ex_bubble = 1'b1;
    end else begin
      if_id_flush = branch_taken || jump;
    end
    stall_cycles = stall_cycles_q;
  end

endmodule
